// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
// Contents: transmitter state encoding, frame constants, the cycle-counter
// width, command byte constants and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_STOP_EDGE = 10;
  localparam int PS2_CNT_W     = 20;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // Parity bit that makes the total count of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchronizer for one PS/2 line with a falling-edge strobe.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   pin_i     : raw PS/2 pin level
//   level_o   : synchronized level
//   neg_o     : one-cycle strobe on a synchronized high-to-low transition
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic neg_o
);

  logic [2:0] sync_q;

  // Reset to the idle (released, pulled-up) level so no false edge appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b111;
    else     sync_q <= {sync_q[1:0], pin_i};
  end

  assign level_o = sync_q[1];
  assign neg_o   = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the clock, issues request-to-send,
// shifts out one command byte on device clock falling edges, then checks the
// device acknowledge bit.
// Ports:
//   clk, rst                 : system clock, asynchronous active-high reset
//   ps2k_clk, ps2k_data      : sampled PS/2 pins
//   ps2_clk_oe, ps2_data_oe  : 1 pulls the respective open-drain pin low
//   tx_data, tx_valid        : command byte and send request
//   tx_ready                 : high only while idle
//   tx_done / tx_err         : one-cycle pulse on ACK / on NACK or timeout
//   busy                     : high while a frame is in progress
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 750_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2k_clk,
  input  logic       ps2k_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy
);

  localparam logic [PS2_CNT_W-1:0] INH_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [PS2_CNT_W-1:0] RTS_LAST = PS2_CNT_W'(RTS_CYCLES - 1);
  localparam logic [PS2_CNT_W-1:0] TO_LAST  = PS2_CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_lvl, clk_neg, data_lvl;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (ps2k_clk),
    .level_o (clk_lvl),
    .neg_o   (clk_neg)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (ps2k_data),
    .level_o (data_lvl),
    .neg_o   ()
  );

  ps2_state_e           state_q, state_d;
  logic [PS2_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]           k_q, k_d;
  logic [7:0]           byte_q, byte_d;
  logic                 par_q, par_d;
  logic                 ack_ok_q, ack_ok_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic [3:0] k_next;
  logic       wd_expired;

  assign k_next     = k_q + 4'd1;
  assign wd_expired = (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    byte_d    = byte_q;
    par_d     = par_q;
    ack_ok_d  = ack_ok_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid) begin
          byte_d   = tx_data;
          par_d    = ps2_odd_parity(tx_data);
          k_d      = '0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;  // start bit, driven while the clock is still held
          state_d   = RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RTS: begin
        if (cnt_q == RTS_LAST) begin
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SEND: begin
        // A device clock edge takes priority over a simultaneous expiry.
        if (clk_neg) begin
          cnt_d = '0;
          k_d   = k_next;
          if (k_next <= 4'(PS2_DATA_BITS)) begin
            data_oe_d = ~byte_q[k_q[2:0]];
          end else if (k_next == 4'(PS2_STOP_EDGE)) begin
            data_oe_d = 1'b0;
            state_d   = ACK;
          end else begin
            data_oe_d = ~par_q;
          end
        end else if (wd_expired) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ACK: begin
        if (clk_neg) begin
          cnt_d    = '0;
          ack_ok_d = ~data_lvl;
          state_d  = WAIT_IDLE;
        end else if (wd_expired) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (clk_lvl & data_lvl) begin
          cnt_d   = '0;
          done_d  = ack_ok_q;
          err_d   = ~ack_ok_q;
          state_d = IDLE;
        end else if (clk_neg) begin
          cnt_d = '0;
        end else if (wd_expired) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        cnt_d     = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      ack_ok_q  <= ack_ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain line model plus a PS/2 device model
// that clocks the frame out, samples data on its rising clock edges and
// answers with ACK or NACK. Expected frames and outcomes are queued when a
// request is driven and compared when the device or the DUT produces them.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 5000;
  localparam int RTSC = 250;
  localparam int TO   = 2000;
  localparam int H    = 30;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2k_clk, ps2k_data;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2k_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2k_data = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ         (50_000_000),
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTSC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2k_clk    (ps2k_clk),
    .ps2k_data   (ps2k_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .busy        (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Outcome codes: 2 = tx_done, 1 = tx_err
  int          out_q[$];
  logic [10:0] frame_q[$];

  int   exp_o;
  logic pulse_prev = 1'b0;

  always @(negedge clk) begin
    if (pulse_prev) check("pulse_width", {30'b0, tx_done, tx_err}, 32'd0);
    if (tx_done | tx_err) begin
      check("done_err_excl", {31'b0, tx_done & tx_err}, 32'd0);
      check("ready_with_pulse", {31'b0, tx_ready}, 32'd1);
      exp_o = (out_q.size() > 0) ? out_q.pop_front() : 0;
      check("outcome", {30'b0, tx_done, tx_err}, exp_o);
    end
    pulse_prev <= tx_done | tx_err;
  end

  // Drives one request; returns at the first negedge after SEND entry with
  // the clock-inhibit length and the cycle at which data_oe first rose.
  task automatic send_req(input logic [7:0] d, input int outcome, input bit push_frame,
                          output int clk_hi, output int data_rise);
    logic par;
    @(negedge clk);
    check("ready_before_req", {31'b0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    par = ($countones(d) % 2 == 0);
    if (outcome != 0) out_q.push_back(outcome);
    if (push_frame) frame_q.push_back({1'b1, par, d, 1'b0});
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    clk_hi    = 0;
    data_rise = -1;
    for (int c = 0; c < INH + RTSC + 100; c++) begin
      if (!ps2_clk_oe) break;
      clk_hi++;
      if (ps2_data_oe && data_rise < 0) data_rise = c;
      @(negedge clk);
    end
  endtask

  // Device side: samples start bit, then generates falling edges; after the
  // stop bit drives the ACK level and gives the final clock pulse.
  task automatic dev_frame(input bit ack_bit, input int nfalls, output logic [10:0] bits);
    bits = '0;
    repeat (5) @(negedge clk);
    bits[0] = ps2k_data;
    for (int i = 1; i <= 10 && i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (4) @(negedge clk);
      bits[i] = ps2k_data;
      repeat (H - 4) @(negedge clk);
    end
    if (nfalls >= 11) begin
      if (!ack_bit) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic score_frame(input logic [10:0] bits);
    logic [10:0] exp_f;
    exp_f = (frame_q.size() > 0) ? frame_q.pop_front() : 11'h7FF;
    check("frame_bits", {21'b0, bits}, {21'b0, exp_f});
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check("return_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "global timeout");
  end

  initial begin
    int          hi, dr, c;
    logic [10:0] bits;
    bit          saw_clk;

    repeat (3) @(negedge clk);
    check("rst_clk_oe",  {31'b0, ps2_clk_oe},  32'd0);
    check("rst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
    check("rst_ready",   {31'b0, tx_ready},    32'd1);
    check("rst_done",    {31'b0, tx_done},     32'd0);
    check("rst_err",     {31'b0, tx_err},      32'd0);
    check("rst_busy",    {31'b0, busy},        32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Set-LED command with ACK, plus inhibit/RTS timing
    send_req(PS2_CMD_SET_LED, 2, 1'b1, hi, dr);
    check("clk_oe_width", hi, INH + RTSC);
    check("data_oe_rise", dr, INH);
    dev_frame(1'b0, 11, bits);
    check("ed_frame_literal", {21'b0, bits}, {21'b0, 11'b1_1_11101101_0});
    score_frame(bits);
    wait_idle();

    // All-zero byte with ACK
    send_req(8'h00, 2, 1'b1, hi, dr);
    dev_frame(1'b0, 11, bits);
    score_frame(bits);
    wait_idle();

    // Reset command answered with NACK
    send_req(PS2_CMD_RESET, 1, 1'b1, hi, dr);
    dev_frame(1'b1, 11, bits);
    score_frame(bits);
    wait_idle();

    // No device clock: watchdog expiry measured from SEND entry
    send_req(8'h55, 1, 1'b0, hi, dr);
    for (c = 0; c < TO + 50; c++) begin
      if (tx_err) break;
      @(negedge clk);
    end
    check("timeout_cycles", c, TO);
    check("timeout_clk_oe",  {31'b0, ps2_clk_oe},  32'd0);
    check("timeout_data_oe", {31'b0, ps2_data_oe}, 32'd0);
    check("timeout_ready",   {31'b0, tx_ready},    32'd1);
    repeat (3) @(negedge clk);

    // Reset mid-frame after the fifth device clock edge
    send_req(8'h00, 0, 1'b0, hi, dr);
    dev_frame(1'b0, 5, bits);
    check("data_oe_at_k5", {31'b0, ps2_data_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_clk_oe",  {31'b0, ps2_clk_oe},  32'd0);
    check("midrst_data_oe", {31'b0, ps2_data_oe}, 32'd0);
    check("midrst_busy",    {31'b0, busy},        32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Second request while busy must be ignored
    send_req(8'hA5, 2, 1'b1, hi, dr);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    repeat (4) @(negedge clk);
    tx_valid = 1'b0;
    dev_frame(1'b0, 11, bits);
    score_frame(bits);
    wait_idle();
    saw_clk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (ps2_clk_oe || busy) saw_clk = 1'b1;
      @(negedge clk);
    end
    check("no_second_frame", {31'b0, saw_clk}, 32'd0);

    check("outcomes_drained", out_q.size(), 32'd0);
    check("frames_drained", frame_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
